ahblite_slave_mux: RTL and testbench
====================================

// Module: ahblite_slave_mux
// PURPOSE
// - AHB-Lite response side of the bus matrix: returns HREADY/HRESP/HRDATA from the slave owning the data phase.
// - Samples the per-port HSEL lines (from the address decoder) in the address phase; holds them for the data phase.
// - Contains a built-in default slave: a transfer to an unmapped address gets the two-cycle AHB ERROR response.
// - Sits between the Cortex-M0 master and ports P0..P5 (RAMCODE, RAMDATA, LCD, UART, Camera, Buzzer).
// PARAMETERS
// - Port0_en  1  RAMCODE port present; 0 = its HSEL is ignored, address treated as unmapped
// - Port1_en  1  RAMDATA port present (same rule)
// - Port2_en  1  LCD port present (same rule)
// - Port3_en  1  UART port present (same rule)
// - Port4_en  1  Camera port present (same rule)
// - Port5_en  0  Buzzer port present (same rule)
// - DEFAULT_ERR  1  1 = unmapped NONSEQ/SEQ gets ERROR; 0 = zero-wait OKAY, HRDATA 0
// PORTS
// - HCLK  in  1  bus clock
// - HRESETn  in  1  asynchronous active-low reset
// - HTRANS  in  2  master transfer type (address phase)
// - P0_HSEL..P5_HSEL  in  1 each  decoder selects (address phase)
// - P0_HREADYOUT..P5_HREADYOUT  in  1 each  slave ready outputs
// - P0_HRESP..P5_HRESP  in  1 each  slave response (0 OKAY, 1 ERROR)
// - P0_HRDATA..P5_HRDATA  in  32 each  slave read data
// - HREADY  out  1  to master and to every slave's HREADY input
// - HRESP  out  1  to master
// - HRDATA  out  32  to master
// BEHAVIOUR
// - Clock HCLK, reset HRESETn asynchronous active-low: that is the only clock/reset scheme.
// - Effective select: selN = PN_HSEL & PortN_en. If several selN are high, the lowest N wins.
// - Unmapped = no effective select.
// - Data-phase select register dsel (7 states: P0..P5, DEF) loads only when HREADY==1.
// - Load rules: the winning port if any, else DEF. Holds while HREADY==0.
// - Mux output, dsel = PN: HREADY=PN_HREADYOUT, HRESP=PN_HRESP, HRDATA=PN_HRDATA. Combinational, no added latency.
// - Mux output, dsel = DEF: HREADY, HRESP and HRDATA come from the default-slave FSM; HRDATA=32'h0.
// - Default FSM states: IDLE, ERR1, ERR2.
//   - IDLE: outputs HREADY=1, HRESP=0.
//   - IDLE->ERR1 when HREADY & unmapped & HTRANS[1] & DEFAULT_ERR.
//   - ERR1: outputs HREADY=0, HRESP=1; always ->ERR2.
//   - ERR2: outputs HREADY=1, HRESP=1.
//   - ERR2->ERR1 if a new unmapped NONSEQ/SEQ is presented in that cycle, else ->IDLE.
// - IDLE/BUSY (HTRANS[1]=0) to an unmapped address: FSM stays IDLE; zero-wait OKAY.
// - HTRANS changes while HREADY==0 are ignored: no resampling of HSEL or HTRANS during a wait state.
// - Reset (any time, including mid-wait or mid-ERROR):
//   - dsel=DEF, FSM=IDLE.
//   - Outputs immediately HREADY=1, HRESP=0, HRDATA=32'h0.
// - First data phase after reset is OKAY, zero-wait (no transfer outstanding).
// - Slave wait states pass straight through. A slave's 2-cycle ERROR passes through unchanged.
// TESTING
// - Reset: assert HRESETn=0 mid-ERR1 -> same cycle HREADY=1, HRESP=0, HRDATA=0; next NONSEQ proceeds normally.
// - Back-to-back ports:
//   - Stimulus: P1_HSEL then P2_HSEL in consecutive address phases, NONSEQ; P1_HRDATA=32'h1234_5678, P2_HRDATA=32'hCAFE_0001.
//   - Response: HRDATA shows 32'h1234_5678 then 32'hCAFE_0001, each in its own data phase.
// - Wait states:
//   - Stimulus: P3 data phase with P3_HREADYOUT low for 3 cycles; P0_HSEL asserted meanwhile.
//   - Response: HREADY low for 3 cycles; dsel stays P3; P0 is selected only after HREADY=1.
// - Unmapped NONSEQ to 0x6000_0000, no HSEL:
//   - Response: next cycle HREADY=0, HRESP=1; following cycle HREADY=1, HRESP=1, HRDATA=0; then OKAY.
// - Unmapped IDLE, and Port5_en=0 with P5_HSEL=1 NONSEQ:
//   - Unmapped IDLE -> zero-wait OKAY.
//   - P5 case -> two-cycle ERROR; P5_HRDATA never appears on HRDATA.
// - Multi-select and ERR2 chaining:
//   - Stimulus: P0_HSEL=P2_HSEL=1 -> Response: P0 response routed.
//   - Stimulus: unmapped NONSEQ presented in ERR2 -> Response: ERR1 follows immediately.

Source files
------------

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response multiplexer for the bus matrix: routes HREADY/HRESP/HRDATA
// from the slave that owns the current data phase, with a built-in default slave.
module ahblite_slave_mux #(
   parameter bit Port0_en    = 1'b1,
   parameter bit Port1_en    = 1'b1,
   parameter bit Port2_en    = 1'b1,
   parameter bit Port3_en    = 1'b1,
   parameter bit Port4_en    = 1'b1,
   parameter bit Port5_en    = 1'b0,
   parameter bit DEFAULT_ERR = 1'b1
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [1:0]  HTRANS,
   input  logic        P0_HSEL,
   input  logic        P1_HSEL,
   input  logic        P2_HSEL,
   input  logic        P3_HSEL,
   input  logic        P4_HSEL,
   input  logic        P5_HSEL,
   input  logic        P0_HREADYOUT,
   input  logic        P1_HREADYOUT,
   input  logic        P2_HREADYOUT,
   input  logic        P3_HREADYOUT,
   input  logic        P4_HREADYOUT,
   input  logic        P5_HREADYOUT,
   input  logic        P0_HRESP,
   input  logic        P1_HRESP,
   input  logic        P2_HRESP,
   input  logic        P3_HRESP,
   input  logic        P4_HRESP,
   input  logic        P5_HRESP,
   input  logic [31:0] P0_HRDATA,
   input  logic [31:0] P1_HRDATA,
   input  logic [31:0] P2_HRDATA,
   input  logic [31:0] P3_HRDATA,
   input  logic [31:0] P4_HRDATA,
   input  logic [31:0] P5_HRDATA,
   output logic        HREADY,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   typedef enum logic [2:0] {
      DSEL_P0  = 3'd0,
      DSEL_P1  = 3'd1,
      DSEL_P2  = 3'd2,
      DSEL_P3  = 3'd3,
      DSEL_P4  = 3'd4,
      DSEL_P5  = 3'd5,
      DSEL_DEF = 3'd6
   } dsel_e;

   typedef enum logic [1:0] {
      DEF_IDLE = 2'd0,
      DEF_ERR1 = 2'd1,
      DEF_ERR2 = 2'd2
   } def_state_e;

   dsel_e      dsel_q, dsel_d;
   def_state_e def_q, def_d;

   logic [5:0] hsel_eff;
   logic       unmapped;
   logic       start_err;
   logic       def_hready;
   logic       def_hresp;
   logic       unused_htrans0;

   // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY.
   assign unused_htrans0 = HTRANS[0];

   assign hsel_eff = {P5_HSEL & Port5_en, P4_HSEL & Port4_en, P3_HSEL & Port3_en,
                      P2_HSEL & Port2_en, P1_HSEL & Port1_en, P0_HSEL & Port0_en};
   assign unmapped  = ~|hsel_eff;
   assign start_err = HREADY & unmapped & HTRANS[1] & DEFAULT_ERR;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dsel_q <= DSEL_DEF;
         def_q  <= DEF_IDLE;
      end else begin
         dsel_q <= dsel_d;
         def_q  <= def_d;
      end
   end

   // Lowest-numbered effective select wins; the register holds during wait states.
   always_comb begin
      dsel_d = dsel_q;
      if (HREADY) begin
         if (hsel_eff[0])      dsel_d = DSEL_P0;
         else if (hsel_eff[1]) dsel_d = DSEL_P1;
         else if (hsel_eff[2]) dsel_d = DSEL_P2;
         else if (hsel_eff[3]) dsel_d = DSEL_P3;
         else if (hsel_eff[4]) dsel_d = DSEL_P4;
         else if (hsel_eff[5]) dsel_d = DSEL_P5;
         else                  dsel_d = DSEL_DEF;
      end
   end

   always_comb begin
      def_d      = DEF_IDLE;
      def_hready = 1'b1;
      def_hresp  = 1'b0;
      case (def_q)
         DEF_ERR1: begin
            def_hready = 1'b0;
            def_hresp  = 1'b1;
            def_d      = DEF_ERR2;
         end
         DEF_ERR2: begin
            def_hresp = 1'b1;
            if (start_err) def_d = DEF_ERR1;
         end
         default: begin
            if (start_err) def_d = DEF_ERR1;
         end
      endcase
   end

   always_comb begin
      HREADY = def_hready;
      HRESP  = def_hresp;
      HRDATA = 32'h0;
      case (dsel_q)
         DSEL_P0: begin HREADY = P0_HREADYOUT; HRESP = P0_HRESP; HRDATA = P0_HRDATA; end
         DSEL_P1: begin HREADY = P1_HREADYOUT; HRESP = P1_HRESP; HRDATA = P1_HRDATA; end
         DSEL_P2: begin HREADY = P2_HREADYOUT; HRESP = P2_HRESP; HRDATA = P2_HRDATA; end
         DSEL_P3: begin HREADY = P3_HREADYOUT; HRESP = P3_HRESP; HRDATA = P3_HRDATA; end
         DSEL_P4: begin HREADY = P4_HREADYOUT; HRESP = P4_HRESP; HRDATA = P4_HRDATA; end
         DSEL_P5: begin HREADY = P5_HREADYOUT; HRESP = P5_HRESP; HRDATA = P5_HRDATA; end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Self-checking bench for ahblite_slave_mux: per-cycle vector table scored
// through an expected-response queue, plus an asynchronous reset sequence.
module tb_ahblite_slave_mux;

   typedef struct {
      string       name;
      logic [1:0]  htrans;
      logic [5:0]  hsel;
      logic [5:0]  ro;
      logic [5:0]  resp;
      logic        exp_ready;
      logic        exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      string       name;
      logic        ready;
      logic        resp;
      logic [31:0] rdata;
   } exp_t;

   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
   localparam logic [31:0] D0 = 32'hA000_0000, D1 = 32'h1234_5678, D2 = 32'hCAFE_0001,
                           D3 = 32'h3333_3333, D4 = 32'h4444_4444, D5 = 32'h5555_5555;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic [1:0]  htrans = T_IDLE;
   logic [5:0]  hsel = 6'b0;
   logic [5:0]  ro = 6'h3F;
   logic [5:0]  resp = 6'h0;
   logic [31:0] rdata [6];
   logic        HREADY, HRESP;
   logic [31:0] HRDATA;

   vec_t vecs[$];
   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   always #5 HCLK = ~HCLK;

   ahblite_slave_mux dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HTRANS(htrans),
      .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]),
      .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]), .P5_HSEL(hsel[5]),
      .P0_HREADYOUT(ro[0]), .P1_HREADYOUT(ro[1]), .P2_HREADYOUT(ro[2]),
      .P3_HREADYOUT(ro[3]), .P4_HREADYOUT(ro[4]), .P5_HREADYOUT(ro[5]),
      .P0_HRESP(resp[0]), .P1_HRESP(resp[1]), .P2_HRESP(resp[2]),
      .P3_HRESP(resp[3]), .P4_HRESP(resp[4]), .P5_HRESP(resp[5]),
      .P0_HRDATA(rdata[0]), .P1_HRDATA(rdata[1]), .P2_HRDATA(rdata[2]),
      .P3_HRDATA(rdata[3]), .P4_HRDATA(rdata[4]), .P5_HRDATA(rdata[5]),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
   );

   task automatic addVec(input string n, input logic [1:0] t, input logic [5:0] s,
                         input logic [5:0] r, input logic [5:0] e,
                         input logic xr, input logic xe, input logic [31:0] xd);
      vec_t v;
      v.name = n; v.htrans = t; v.hsel = s; v.ro = r; v.resp = e;
      v.exp_ready = xr; v.exp_resp = xe; v.exp_rdata = xd;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t x;
      htrans = v.htrans;
      hsel   = v.hsel;
      ro     = v.ro;
      resp   = v.resp;
      x.name = v.name; x.ready = v.exp_ready; x.resp = v.exp_resp; x.rdata = v.exp_rdata;
      sb.push_back(x);
   endtask

   task automatic checkOutput();
      exp_t x;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_empty: no expected entry for observed %b/%b/%h",
                  HREADY, HRESP, HRDATA);
      end else begin
         x = sb.pop_front();
         if (HREADY !== x.ready || HRESP !== x.resp || HRDATA !== x.rdata) begin
            bad++;
            $display("[TB] FAIL %s: got ready=%b resp=%b rdata=%h, want ready=%b resp=%b rdata=%h",
                     x.name, HREADY, HRESP, HRDATA, x.ready, x.resp, x.rdata);
         end
      end
   endtask

   task automatic expectNow(input string n, input logic xr, input logic xe, input logic [31:0] xd);
      exp_t x;
      x.name = n; x.ready = xr; x.resp = xe; x.rdata = xd;
      sb.push_back(x);
      checkOutput();
   endtask

   initial begin
      rdata[0] = D0; rdata[1] = D1; rdata[2] = D2;
      rdata[3] = D3; rdata[4] = D4; rdata[5] = D5;

      // Each row: address-phase inputs and slave responses for this cycle,
      // with the mux outputs expected during the same cycle.
      addVec("post_reset_idle",  T_IDLE, 6'b000000, 6'h3F, 6'h00, 1, 0, 32'h0);
      addVec("addr_p1",          T_NSEQ, 6'b000010, 6'h3F, 6'h00, 1, 0, 32'h0);
      addVec("data_p1",          T_NSEQ, 6'b000100, 6'h3F, 6'h00, 1, 0, D1);
      addVec("data_p2",          T_NSEQ, 6'b001000, 6'h3F, 6'h00, 1, 0, D2);
      addVec("p3_wait1",         T_NSEQ, 6'b000001, 6'h37, 6'h00, 0, 0, D3);
      addVec("p3_wait2",         T_NSEQ, 6'b000001, 6'h37, 6'h00, 0, 0, D3);
      addVec("p3_wait3",         T_NSEQ, 6'b000001, 6'h37, 6'h00, 0, 0, D3);
      addVec("p3_done",          T_NSEQ, 6'b000001, 6'h3F, 6'h00, 1, 0, D3);
      addVec("data_p0",          T_NSEQ, 6'b000000, 6'h3F, 6'h00, 1, 0, D0);
      addVec("unmapped_err1",    T_IDLE, 6'b000000, 6'h3F, 6'h00, 0, 1, 32'h0);
      addVec("unmapped_err2",    T_IDLE, 6'b000000, 6'h3F, 6'h00, 1, 1, 32'h0);
      addVec("after_err_okay",   T_IDLE, 6'b000000, 6'h3F, 6'h00, 1, 0, 32'h0);
      addVec("p5_disabled_addr", T_NSEQ, 6'b100000, 6'h3F, 6'h00, 1, 0, 32'h0);
      addVec("p5_err1",          T_IDLE, 6'b000000, 6'h3F, 6'h00, 0, 1, 32'h0);
      addVec("p5_err2_chain",    T_NSEQ, 6'b000000, 6'h3F, 6'h00, 1, 1, 32'h0);
      addVec("chain_err1",       T_IDLE, 6'b000000, 6'h3F, 6'h00, 0, 1, 32'h0);
      addVec("chain_err2",       T_IDLE, 6'b000000, 6'h3F, 6'h00, 1, 1, 32'h0);
      addVec("multi_sel_addr",   T_NSEQ, 6'b000101, 6'h3F, 6'h00, 1, 0, 32'h0);
      addVec("multi_sel_p0",     T_IDLE, 6'b000000, 6'h3B, 6'h04, 1, 0, D0);
      addVec("seq_p4_addr",      T_SEQ,  6'b010000, 6'h3F, 6'h00, 1, 0, 32'h0);
      addVec("p4_slave_err1",    T_IDLE, 6'b000000, 6'h2F, 6'h10, 0, 1, D4);
      addVec("p4_slave_err2",    T_IDLE, 6'b000000, 6'h3F, 6'h10, 1, 1, D4);
      addVec("busy_unmapped",    T_BUSY, 6'b000000, 6'h3F, 6'h00, 1, 0, 32'h0);
      addVec("busy_no_err",      T_IDLE, 6'b000000, 6'h3F, 6'h00, 1, 0, 32'h0);
      addVec("reset_setup_addr", T_NSEQ, 6'b000000, 6'h3F, 6'h00, 1, 0, 32'h0);
      addVec("reset_setup_err1", T_IDLE, 6'b000000, 6'h3F, 6'h00, 0, 1, 32'h0);

      repeat (3) @(posedge HCLK);
      #1 HRESETn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge HCLK);
         #1 applyStimulus(vecs[i]);
         @(negedge HCLK);
         checkOutput();
      end

      // Reset asserted in the middle of ERR1 must release the bus immediately.
      #1 HRESETn = 1'b0;
      #1 expectNow("reset_mid_err1", 1'b1, 1'b0, 32'h0);
      @(posedge HCLK);
      #1 HRESETn = 1'b1;
      htrans = T_NSEQ; hsel = 6'b000010; ro = 6'h3F; resp = 6'h00;
      @(negedge HCLK);
      expectNow("post_reset_addr_p1", 1'b1, 1'b0, 32'h0);
      @(posedge HCLK);
      #1 htrans = T_IDLE; hsel = 6'b0;
      @(negedge HCLK);
      expectNow("post_reset_data_p1", 1'b1, 1'b0, D1);

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
